// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: restoring unsigned divider q=a/b r=a%b; in clk rst_n start a b, out busy done q r div_by_zero
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] dvd, dvs, dvd_nx, rem, rem_nx;
  logic [WIDTH:0] rem_sh, diff;
  logic [CW-1:0] cnt;
  logic ge, last, accept;
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff = rem_sh - {1'b0, dvs};
    ge = !diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nx = {dvd[WIDTH-2:0], ge};
    last = cnt == CW'(WIDTH - 1);
    accept = state == IDLE && start;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept && b != '0 ? RUN : IDLE) : (last ? IDLE : RUN);
  always_comb busy = state == RUN;
  always_ff @(posedge clk)
    if (!rst_n) begin
      done <= 1'b0;
      q <= '0;
      r <= '0;
      div_by_zero <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept && b == '0) begin
        q <= '1;
        r <= a;
        div_by_zero <= 1'b1;
        done <= 1'b1;
      end else if (accept) begin
        dvd <= a;
        dvs <= b;
        rem <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        dvd <= dvd_nx;
        rem <= rem_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          q <= dvd_nx;
          r <= rem_nx;
          div_by_zero <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: randomized and directed checks of seq_divider_16bit against an arithmetic model
module tb_seq_divider_16bit;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0, q, r;
  logic busy, done, dz;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  seq_divider_16bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(dz)
  );
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, output logic [W-1:0] oq,
                        output logic [W-1:0] orr, output logic oz, output int lat, output int bc);
    a_i = ta;
    b_i = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 64) begin
      bc += int'(busy);
      @(negedge clk);
      lat++;
    end
    oq = q;
    orr = r;
    oz = dz;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    a_i = 16'd77;
    b_i = 16'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, done, dz, q, r} !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, required all 0", busy, done, dz, q, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    logic [W-1:0] oq, orr;
    logic oz;
    int lat, bc;
    run_op(16'd100, 16'd7, oq, orr, oz, lat, bc);
    vectors++;
    if ({oq, orr, oz} !== {16'd14, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b, required q=14 r=2 dz=0", oq, orr, oz);
    end
    vectors++;
    if (lat !== W || bc !== W || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_timing: latency=%0d busy_cycles=%0d busy_at_done=%b, required %0d %0d 0", lat, bc, busy, W, W);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || q !== 16'd14 || r !== 16'd2) begin
      miscompares++;
      $display("FAIL basic_pulse: done=%b q=%0d r=%0d after pulse, required done=0 q=14 r=2", done, q, r);
    end
  endtask
  task automatic test_extremes;
    logic [W-1:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'd3, 16'd0};
    logic [W-1:0] tb[4] = '{16'd1, 16'hFFFF, 16'd10, 16'd9};
    logic [W-1:0] eq[4] = '{16'hFFFF, 16'd1, 16'd0, 16'd0};
    logic [W-1:0] er[4] = '{16'd0, 16'd0, 16'd3, 16'd0};
    logic [W-1:0] oq, orr;
    logic oz;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], oq, orr, oz, lat, bc);
      vectors++;
      if ({oq, orr, oz} !== {eq[i], er[i], 1'b0} || lat !== W) begin
        miscompares++;
        $display("FAIL extreme_%0d: %h/%h gave q=%h r=%h dz=%b lat=%0d, required q=%h r=%h dz=0 lat=%0d",
                 i, ta[i], tb[i], oq, orr, oz, lat, eq[i], er[i], W);
      end
    end
  endtask
  task automatic test_div_zero;
    logic [W-1:0] oq, orr;
    logic oz;
    int lat, bc;
    run_op(16'd5, 16'd0, oq, orr, oz, lat, bc);
    vectors++;
    if ({oq, orr, oz} !== {16'hFFFF, 16'd5, 1'b1} || lat !== 0 || bc !== 0) begin
      miscompares++;
      $display("FAIL div_zero: q=%h r=%0d dz=%b lat=%0d busy_cycles=%0d, required FFFF 5 1 0 0", oq, orr, oz, lat, bc);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || dz !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero_hold: done=%b busy=%b dz=%b, required 0 0 1", done, busy, dz);
    end
    run_op(16'd9, 16'd3, oq, orr, oz, lat, bc);
    vectors++;
    if ({oq, orr, oz} !== {16'd3, 16'd0, 1'b0} || lat !== W) begin
      miscompares++;
      $display("FAIL div_zero_follow: q=%0d r=%0d dz=%b lat=%0d, required 3 0 0 %0d", oq, orr, oz, lat, W);
    end
  endtask
  task automatic test_ignore_busy;
    int ndone = 0;
    logic [W-1:0] oq = '0, orr = '0;
    a_i = 16'd50;
    b_i = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a_i = 16'd9;
    b_i = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ndone++;
        oq = q;
        orr = r;
      end
      @(negedge clk);
    end
    vectors++;
    if (ndone !== 1 || oq !== 16'd10 || orr !== 16'd0) begin
      miscompares++;
      $display("FAIL ignore_busy: dones=%0d q=%0d r=%0d, required 1 10 0", ndone, oq, orr);
    end
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] oq, orr;
    logic oz;
    int lat, bc;
    run_op(16'd1234, 16'd11, oq, orr, oz, lat, bc);
    run_op(16'd4321, 16'd17, oq, orr, oz, lat, bc);
    vectors++;
    if ({oq, orr, oz} !== {16'd254, 16'd3, 1'b0} || lat !== W || bc !== W) begin
      miscompares++;
      $display("FAIL back_to_back: q=%0d r=%0d dz=%b lat=%0d busy_cycles=%0d, required 254 3 0 %0d %0d",
               oq, orr, oz, lat, bc, W, W);
    end
  endtask
  task automatic test_reset_mid;
    int ndone = 0;
    logic [W-1:0] oq, orr;
    logic oz;
    int lat, bc;
    a_i = 16'd1000;
    b_i = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ndone += int'(done);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    ndone += int'(done);
    vectors++;
    if (busy !== 1'b0 || q !== '0 || r !== '0 || ndone !== 0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b q=%0d r=%0d dones=%0d, required 0 0 0 0", busy, q, r, ndone);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd1000, 16'd3, oq, orr, oz, lat, bc);
    vectors++;
    if ({oq, orr, oz} !== {16'd333, 16'd1, 1'b0} || lat !== W) begin
      miscompares++;
      $display("FAIL reset_mid_after: q=%0d r=%0d dz=%b lat=%0d, required 333 1 0 %0d", oq, orr, oz, lat, W);
    end
  endtask
  task automatic test_random;
    logic [W-1:0] ta, tb, oq, orr, eq, er;
    logic oz, ez;
    int lat, bc, el;
    for (int i = 0; i < 2000; i++) begin
      ta = W'($urandom);
      tb = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 20)) : W'($urandom);
      if (tb == '0) {eq, er, ez, el} = {16'hFFFF, ta, 1'b1, 32'd0};
      else {eq, er, ez, el} = {ta / tb, ta % tb, 1'b0, W};
      run_op(ta, tb, oq, orr, oz, lat, bc);
      vectors++;
      if ({oq, orr, oz} !== {eq, er, ez} || lat !== el) begin
        miscompares++;
        $display("FAIL random_%0d: %0d/%0d gave q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=%b lat=%0d",
                 i, ta, tb, oq, orr, oz, lat, eq, er, ez, el);
      end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_extremes;
    test_div_zero;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
